traffic_controller_top: RTL and testbench



---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_controller_top_dwell_timer.sv | 21 ++
 rtl/traffic_controller_top.sv | 68 ++++++
 tb/tb_traffic_controller_top.sv | 134 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the two-way traffic-light controller.
package traffic_pkg;

  localparam int GREEN_MIN_DEF = 5;
  localparam int GREEN_MAX_DEF = 20;
  localparam int YELLOW_DEF    = 3;

  // Right-of-way states, in the order the light sequence visits them.
  typedef enum logic [1:0] {
    AG = 2'd0,
    AY = 2'd1,
    BG = 2'd2,
    BY = 2'd3
  } state_t;

  typedef struct packed {
    logic ga, ya, ra;
    logic gb, yb, rb;
  } lamps_t;

  // Successor in the fixed AG -> AY -> BG -> BY -> AG cycle.
  function automatic state_t next_state(input state_t s);
    state_t n;
    unique case (s)
      AG:      n = AY;
      AY:      n = BG;
      BG:      n = BY;
      default: n = AG;
    endcase
    return n;
  endfunction

  // Lamp pattern for a state; the opposite road is always red.
  function automatic lamps_t decode(input state_t s);
    lamps_t l;
    l = '0;
    unique case (s)
      AG:      begin l.ga = 1'b1; l.rb = 1'b1; end
      AY:      begin l.ya = 1'b1; l.rb = 1'b1; end
      BG:      begin l.ra = 1'b1; l.gb = 1'b1; end
      default: begin l.ra = 1'b1; l.yb = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_controller_top_dwell_timer.sv
// Dwell timer: counts cycles spent in the current state, saturating at MAX.
module dwell_timer #(
  parameter int MAX = 20,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  // Clear on state change/reset, otherwise count up and hold at MAX.
  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_controller_top.sv
// Two-way intersection controller: Moore FSM with min/max green and fixed
// yellow intervals, lamps registered alongside the state.
module traffic_controller_top
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW    = YELLOW_DEF
) (
  input  logic clk,
  input  logic reset_n,   // active-high synchronous reset
  input  logic Sa,
  input  logic Sb,
  output logic Ga,
  output logic Ya,
  output logic Ra,
  output logic Gb,
  output logic Yb,
  output logic Rb
);

  localparam int CW = $clog2(GREEN_MAX + 1);
  localparam logic [CW-1:0] MIN_T = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] MAX_T = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_T = CW'(YELLOW - 1);

  state_t        state;
  lamps_t        lamps;
  logic          go;
  logic [CW-1:0] cnt;

  // Counter restarts whenever the state changes so each state sees cnt=0 first.
  dwell_timer #(.MAX(GREEN_MAX), .W(CW)) u_timer (
    .clk   (clk),
    .clear (reset_n | go),
    .cnt   (cnt)
  );

  // Leave-state condition; sensors only matter while a road is green.
  always_comb begin
    go = 1'b0;
    unique case (state)
      AG:      go = (cnt >= MIN_T && !Sa) || (cnt >= MAX_T && Sb);
      BG:      go = (cnt >= MIN_T && !Sb) || (cnt >= MAX_T && Sa);
      default: go = (cnt == YEL_T);
    endcase
  end

  // State register with lamps decoded from the next state, so lamps change
  // right after the edge that takes the transition.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= AG;
      lamps <= decode(AG);
    end else if (go) begin
      state <= next_state(state);
      lamps <= decode(next_state(state));
    end
  end

  assign Ga = lamps.ga;
  assign Ya = lamps.ya;
  assign Ra = lamps.ra;
  assign Gb = lamps.gb;
  assign Yb = lamps.yb;
  assign Rb = lamps.rb;

endmodule

// File: tb/tb_traffic_controller_top.sv
// Bench for traffic_controller_top: directed scenarios plus random sensors,
// checked every cycle against a phase/elapsed-time reference model.
module tb_traffic_controller_top;

  localparam int GMIN = 5;
  localparam int GMAX = 20;
  localparam int YEL  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic Sa = 1'b0, Sb = 1'b0;
  logic Ga, Ya, Ra, Gb, Yb, Rb;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0=A green,1=A yellow,2=B green,3=B yellow.
  int ph = 0;
  int t  = 0;    // cycles already spent in phase (unbounded)
  int len_q[$];  // completed phase lengths, for duration checks
  int run = 0;

  traffic_controller_top #(.GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW(YEL)) dut (
    .clk(clk), .reset_n(reset_n), .Sa(Sa), .Sb(Sb),
    .Ga(Ga), .Ya(Ya), .Ra(Ra), .Gb(Gb), .Yb(Yb), .Rb(Rb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge using the sensor/reset values at that edge.
  task automatic model_edge();
    bit leave;
    if (reset_n) begin
      ph = 0; t = 0; run = 0;
      return;
    end
    // Elapsed cycles in green = t+1 after this edge; yellow fixed at YEL.
    case (ph)
      0:       leave = (t + 1 >= GMIN && !Sa) || (t + 1 >= GMAX && Sb);
      2:       leave = (t + 1 >= GMIN && !Sb) || (t + 1 >= GMAX && Sa);
      default: leave = (t + 1 == YEL);
    endcase
    if (leave) begin
      len_q.push_back(t + 1);
      ph = (ph + 1) % 4;
      t = 0;
    end else begin
      t++;
    end
  endtask

  task automatic step(input bit rst, input bit a, input bit b);
    reset_n = rst; Sa = a; Sb = b;
    @(posedge clk);
    model_edge();
    #1;
    chk("lamps", {Ga, Ya, Ra, Gb, Yb, Rb},
        {ph == 0, ph == 1, ph >= 2, ph == 2, ph == 3, ph < 2});
    chk("onehot_a", $countones({Ga, Ya, Ra}), 1);
    chk("onehot_b", $countones({Gb, Yb, Rb}), 1);
    chk("no_conflict", int'((Ga | Ya) & (Gb | Yb)), 0);
  endtask

  // Run until the model is sitting in phase p at its start, bounded.
  task automatic run_to(input int p, input bit a, input bit b);
    int guard = 0;
    while (!(ph == p && t == 0) && guard < 200) begin
      step(1'b0, a, b);
      guard++;
    end
    chk("run_to_bound", int'(guard < 200), 1);
  endtask

  initial begin
    // Reset with A waiting only: A holds green indefinitely.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("reset_lamps", {Ga, Ya, Ra, Gb, Yb, Rb}, 6'b100001);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0);
    chk("a_held_green", Ga, 1);

    // No traffic: minimum timings, period 16.
    step(1'b1, 1'b0, 1'b0);
    len_q.delete();
    for (int i = 0; i < 48; i++) step(1'b0, 1'b0, 1'b0);
    chk("min_ag", len_q[0], GMIN);
    chk("min_ay", len_q[1], YEL);
    chk("min_bg", len_q[2], GMIN);
    chk("min_by", len_q[3], YEL);
    chk("min_ph_at_16", int'(len_q.size() >= 8), 1);

    // Both waiting: each green exactly GREEN_MAX.
    step(1'b1, 1'b1, 1'b1);
    len_q.delete();
    for (int i = 0; i < 2 * (2 * GMAX + 2 * YEL); i++) step(1'b0, 1'b1, 1'b1);
    chk("max_ag", len_q[0], GMAX);
    chk("max_ay", len_q[1], YEL);
    chk("max_bg", len_q[2], GMAX);
    chk("max_by", len_q[3], YEL);

    // A holds 10 cycles, then drops: yellow right at the next edge.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("late_drop_ya", Ya, 1);
    step(1'b0, 1'b0, 1'b0);   // second yellow cycle begins after this edge
    chk("second_ya", Ya, 1);
    // Reset during the second yellow cycle: back to A green, full min green.
    step(1'b1, 1'b0, 1'b0);
    chk("reset_mid_yellow", {Ga, Ya, Rb}, 3'b101);
    len_q.delete();
    run_to(2, 1'b0, 1'b0);
    chk("min_after_reset", len_q[0], GMIN);

    // Random sensors with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit r = ($urandom_range(0, 299) == 0);
      step(r, ($urandom_range(0, 3) != 0) ? Sa : 1'($urandom),
              ($urandom_range(0, 3) != 0) ? Sb : 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
